// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB arbiter: default widths,
// access timeout and the transfer FSM state encoding.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 10;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: one-hot grant from the pending requests and a
// pointer remembering which requester was granted last.
module apb_rr_arbiter
  import apb_pkg::*;
(
  input  logic       pclk,
  input  logic       PRESET,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last_grant
);

  // Under contention the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = idx_to_onehot(~last_grant);
      default: grant = 2'b00;
    endcase
  end

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      last_grant <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Arbitrates two request ports onto one APB master: round-robin accept,
// SETUP/ACCESS sequencing with a pready timeout, one-cycle response pulse.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                       pclk,
  input  logic                       PRESET,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic                       pwrite,
  output logic                       psel,
  output logic                       penable,
  output logic [DATA_WIDTH-1:0]      pwdata,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pready
);

  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t     state;
  logic [TCW-1:0] tcount;
  logic [1:0]     grant;
  logic           last_grant;
  logic           gidx;
  logic           accept;

  assign accept    = (state == IDLE) && (req_valid != 2'b00);
  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign gidx      = grant[1];

  apb_rr_arbiter u_rr (
    .pclk       (pclk),
    .PRESET     (PRESET),
    .req        (req_valid),
    .update     (accept),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // The pointer is updated on every accept, so it also names the owner of
  // the transfer in flight and selects which rsp_valid bit to pulse.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      state     <= IDLE;
      tcount    <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            paddr  <= req_addr[gidx];
            pwrite <= req_write[gidx];
            pwdata <= req_wdata[gidx];
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          tcount  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            rsp_valid <= idx_to_onehot(last_grant);
            state     <= RESP;
          end else if (tcount == TCW'(TIMEOUT - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= idx_to_onehot(last_grant);
            state     <= RESP;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level reference model.
module tb_apb_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic                pclk = 1'b0;
  logic                PRESET;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic [AW-1:0]       paddr;
  logic                pwrite;
  logic                psel;
  logic                penable;
  logic [DW-1:0]       pwdata;
  logic [DW-1:0]       prdata;
  logic                pready;

  int checks   = 0;
  int failures = 0;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .pclk      (pclk),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 pclk = ~pclk;

  // Memory slave: pready after waitCfg wait states; huge waitCfg never answers.
  bit [DW-1:0] mem [1024];
  bit [DW-1:0] refMem [1024];
  int waitCfg = 0;
  int accCnt  = 0;

  always @(posedge pclk) begin
    accCnt <= (psel && penable && !pready) ? accCnt + 1 : 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  assign pready = psel && penable && (accCnt >= waitCfg);
  assign prdata = mem[paddr];

  typedef struct {
    int          who;
    bit          write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] expRdata;
    bit          expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge pclk);
    #2;
  endtask

  task automatic doReset();
    PRESET    = 1'b1;
    req_valid = 2'b00;
    nextCycle();
    nextCycle();
    PRESET = 1'b0;
  endtask

  // One isolated transfer: accept, SETUP/ACCESS shape, latency and response.
  task automatic applyStimulus(input vec_t v, input int idx);
    int    lat;
    bit    got;
    string tag;
    tag = $sformatf("vec%0d", idx);
    waitCfg = v.waits;
    req_write[v.who] = v.write;
    req_addr[v.who]  = v.addr;
    req_wdata[v.who] = v.wdata;
    req_valid = oh(v.who);
    #1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (req_ready != 2'b00) got = 1'b1;
      else begin
        nextCycle();
        #1;
      end
    end
    check({tag, " accept"}, 64'(req_ready), 64'(oh(v.who)));
    nextCycle();
    req_valid = 2'b00;
    lat = 1;
    while (lat < 40 && rsp_valid == 2'b00) begin
      check({tag, " phase"}, 64'({psel, penable, pwrite, paddr, pwdata}),
            64'({1'b1, lat >= 2, v.write, v.addr, v.wdata}));
      nextCycle();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(v.expLat));
    check({tag, " rsp"}, 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({oh(v.who), v.expErr, v.expRdata}));
    check({tag, " bus idle"}, 64'({psel, penable}), 64'(0));
    nextCycle();
    check({tag, " pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  task automatic checkOutput();
    check("reset apb", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
    check("reset rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    check("reset ready", 64'(req_ready), 64'(0));
  endtask

  task automatic contention();
    int order[4];
    int when[4];
    int n = 0;
    doReset();
    waitCfg = 0;
    req_write = 2'b00;
    req_addr[0] = 10'h040;
    req_addr[1] = 10'h041;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (req_ready != 2'b00) begin
        order[n] = req_ready[1] ? 1 : 0;
        when[n]  = c;
        n++;
      end
      nextCycle();
      #1;
    end
    req_valid = 2'b00;
    check("contention count", 64'(n), 64'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("contention grant%0d", i), 64'(order[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++)
      check($sformatf("contention gap%0d", i), 64'(when[i] - when[i-1]), 64'(4));
    repeat (6) nextCycle();
  endtask

  task automatic resetMidAccess();
    int bad = 0;
    bit got = 1'b0;
    waitCfg = 1000;
    req_write[0] = 1'b0;
    req_addr[0]  = 10'h040;
    req_valid    = 2'b01;
    #1;
    for (int i = 0; i < 8 && !got; i++) begin
      if (req_ready != 2'b00) got = 1'b1;
      else begin
        nextCycle();
        #1;
      end
    end
    check("rst accept", 64'(req_ready), 64'(2'b01));
    nextCycle();
    req_valid = 2'b00;
    nextCycle();
    check("rst in access", 64'({psel, penable}), 64'(2'b11));
    nextCycle();
    nextCycle();
    PRESET = 1'b1;
    nextCycle();
    check("rst drop", 64'({psel, penable, rsp_valid, paddr, pwdata}), 64'(0));
    PRESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      if (rsp_valid != 2'b00) bad++;
    end
    check("rst no rsp", 64'(bad), 64'(0));
    waitCfg = 0;
    req_valid = 2'b11;
    #1;
    check("rst regrant", 64'(req_ready), 64'(2'b01));
    nextCycle();
    req_valid = 2'b00;
    repeat (6) nextCycle();
  endtask

  // Reference model: transfers are whole transactions with a due cycle.
  task automatic randomPhase();
    int          lastServed = 1;
    bit          inFlight = 1'b0;
    bit          respNow;
    int          owner = 0, acceptC = 0, respDue = 0, w, winner;
    logic [31:0] expData = '0;
    bit          expErr = 1'b0;
    bit          expSel, expEn;
    bit [1:0]    pend = 2'b00;
    bit [1:0]    pw = 2'b00;
    logic [9:0]  pa[2];
    logic [31:0] pd[2];
    logic [9:0]  fa = '0;
    bit          fw = 1'b0;
    logic [31:0] fd = '0;
    int          served[2];
    served[0] = 0;
    served[1] = 0;
    pa[0] = 10'h100; pa[1] = 10'h100;
    pd[0] = '0;      pd[1] = '0;
    doReset();
    for (int c = 0; c < 1500; c++) begin
      respNow = 1'b0;
      if (inFlight && c == respDue) begin
        check("rand rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({oh(owner), expErr, expData}));
        if (fw && !expErr) refMem[fa] = fd;
        inFlight = 1'b0;
        respNow  = 1'b1;
      end else begin
        check("rand no rsp", 64'(rsp_valid), 64'(0));
      end
      expSel = inFlight && (c > acceptC);
      expEn  = inFlight && (c >= acceptC + 2);
      check("rand apb ctl", 64'({psel, penable}), 64'({expSel, expEn}));
      if (expSel) check("rand apb bus", 64'({pwrite, paddr, pwdata}), 64'({fw, fa, fd}));
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) == 0) begin
          pend[r] = 1'b1;
          pw[r]   = 1'($urandom_range(0, 1));
          pa[r]   = 10'h100 + 10'($urandom_range(0, 7));
          pd[r]   = $urandom;
        end
      end
      req_valid = pend;
      req_write = pw;
      req_addr[0] = pa[0];  req_addr[1] = pa[1];
      req_wdata[0] = pd[0]; req_wdata[1] = pd[1];
      #1;
      winner = -1;
      if (!inFlight && !respNow && pend != 2'b00)
        winner = (pend == 2'b11) ? 1 - lastServed : (pend[1] ? 1 : 0);
      check("rand accept", 64'(req_ready), 64'((winner < 0) ? 2'b00 : oh(winner)));
      if (winner >= 0) begin
        inFlight   = 1'b1;
        owner      = winner;
        acceptC    = c;
        lastServed = winner;
        served[winner]++;
        fw = pw[winner];
        fa = pa[winner];
        fd = pd[winner];
        pend[winner] = 1'b0;
        w = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
        waitCfg = w;
        expErr  = (w >= TMO);
        respDue = expErr ? c + 2 + TMO : c + 3 + w;
        expData = (fw || expErr) ? 32'h0 : refMem[fa];
      end
      nextCycle();
    end
    req_valid = 2'b00;
    check("rand served0", 64'(served[0] > 20), 64'(1));
    check("rand served1", 64'(served[1] > 20), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run exceeded its time limit, t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESET    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    vecs[0] = '{0, 1'b1, 10'h010, 32'hDEADBEEF, 0,    32'h0,        1'b0, 3};
    vecs[1] = '{1, 1'b0, 10'h010, 32'h0,        0,    32'hDEADBEEF, 1'b0, 3};
    vecs[2] = '{1, 1'b1, 10'h3FF, 32'h12345678, 2,    32'h0,        1'b0, 5};
    vecs[3] = '{0, 1'b0, 10'h3FF, 32'h0,        1,    32'h12345678, 1'b0, 4};
    vecs[4] = '{0, 1'b1, 10'h020, 32'hA5A5A5A5, 15,   32'h0,        1'b0, 18};
    vecs[5] = '{1, 1'b0, 10'h020, 32'h0,        16,   32'h0,        1'b1, 18};
    vecs[6] = '{0, 1'b0, 10'h020, 32'h0,        0,    32'hA5A5A5A5, 1'b0, 3};
    vecs[7] = '{1, 1'b1, 10'h020, 32'hFFFFFFFF, 1000, 32'h0,        1'b1, 18};
    vecs[8] = '{0, 1'b0, 10'h020, 32'h0,        0,    32'hA5A5A5A5, 1'b0, 3};

    doReset();
    checkOutput();
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);
    contention();
    resetMidAccess();
    randomPhase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
